// File: rtl/sram_db_pkg.sv
// Shared constants and types for the banked ping-pong SRAM.
package sram_db_pkg;

  // Geometry of one sky130_sram_2kbyte_1rw1r_32x512_8 macro.
  localparam int unsigned MACRO_DEPTH = 512;
  localparam int unsigned MACRO_WIDTH = 32;
  localparam int unsigned MACRO_AW    = 9;

  // Number of filled buffers waiting for the consumer: 0, 1 or 2.
  typedef logic [1:0] full_cnt_t;

  localparam full_cnt_t FullCntEmpty = 2'd0;
  localparam full_cnt_t FullCntMax   = 2'd2;

endpackage

// File: rtl/sky130_sram_2kbyte_1rw1r_32x512_8.sv
// Behavioural stand-in for the 32x512 1rw1r sky130 SRAM macro.
// Port 0 writes (byte-masked) or reads; port 1 is read-only. Chip selects and
// write enable are active-low. Port 1 read data is presented for the whole
// cycle after the one following the access, so it can be sampled one edge
// later than the access edge plus one.
module sky130_sram_2kbyte_1rw1r_32x512_8 (
  input  logic        clk0,
  input  logic        csb0,
  input  logic        web0,
  input  logic [3:0]  wmask0,
  input  logic [8:0]  addr0,
  input  logic [31:0] din0,
  output logic [31:0] dout0,
  input  logic        clk1,
  input  logic        csb1,
  input  logic [8:0]  addr1,
  output logic [31:0] dout1
);

  logic [31:0] mem [512];
  logic [31:0] rd_hold_q;
  logic        rd_pend_q;

  // Port 0: byte-masked write, or read when web0 is high.
  always_ff @(posedge clk0) begin
    if (!csb0 && !web0) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask0[i]) begin
          mem[addr0][i*8 +: 8] <= din0[i*8 +: 8];
        end
      end
    end
    if (!csb0 && web0) begin
      dout0 <= mem[addr0];
    end
  end

  // Port 1: array access at the request edge, output updated on the next edge.
  always_ff @(posedge clk1) begin
    rd_pend_q <= !csb1;
    if (!csb1) begin
      rd_hold_q <= mem[addr1];
    end
    if (rd_pend_q) begin
      dout1 <= rd_hold_q;
    end
  end

endmodule

// File: rtl/sram_bank_array.sv
// One ping-pong buffer: DEPTH/512 rows by DATA_WIDTH/32 columns of macros.
// Decodes per-row chip selects, tracks the row of each in-flight read and
// muxes the returning macro row onto rd_data_o.
module sram_bank_array
  import sram_db_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2048,
  parameter int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [AW-1:0]         rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int unsigned NumRows = DEPTH / MACRO_DEPTH;
  localparam int unsigned NumCols = DATA_WIDTH / MACRO_WIDTH;
  localparam int unsigned RowW    = (AW > MACRO_AW) ? AW - MACRO_AW : 1;

  logic [RowW-1:0] wr_row;
  logic [RowW-1:0] rd_row;
  logic [RowW-1:0] rd_row_q;
  logic [RowW-1:0] rd_row_qq;

  logic [NumRows*DATA_WIDTH-1:0] rd_dout;
  logic [NumRows*DATA_WIDTH-1:0] unused_dout0;

  if (AW > MACRO_AW) begin : g_row_sel
    assign wr_row = wr_addr_i[AW-1:MACRO_AW];
    assign rd_row = rd_addr_i[AW-1:MACRO_AW];
  end else begin : g_row_single
    assign wr_row = '0;
    assign rd_row = '0;
  end

  for (genvar r = 0; r < NumRows; r++) begin : g_tile_row
    logic csb0;
    logic csb1;
    // At most one row per port is selected in any cycle.
    assign csb0 = !(wr_en_i && (wr_row == RowW'(r)));
    assign csb1 = !(rd_en_i && (rd_row == RowW'(r)));

    for (genvar c = 0; c < NumCols; c++) begin : g_tile_col
      sky130_sram_2kbyte_1rw1r_32x512_8 u_macro (
        .clk0   (clk_i),
        .csb0   (csb0),
        .web0   (1'b0),
        .wmask0 (4'hF),
        .addr0  (wr_addr_i[MACRO_AW-1:0]),
        .din0   (wr_data_i[c*MACRO_WIDTH +: MACRO_WIDTH]),
        .dout0  (unused_dout0[(r*NumCols + c)*MACRO_WIDTH +: MACRO_WIDTH]),
        .clk1   (clk_i),
        .csb1   (csb1),
        .addr1  (rd_addr_i[MACRO_AW-1:0]),
        .dout1  (rd_dout[(r*NumCols + c)*MACRO_WIDTH +: MACRO_WIDTH])
      );
    end
  end

  // Row select captured at accept, then aligned with the macro output cycle.
  always_ff @(posedge clk_i) begin
    if (rd_en_i) begin
      rd_row_q <= rd_row;
    end
    rd_row_qq <= rd_row_q;
  end

  // Select the macro row belonging to the read whose data is on the outputs.
  always_comb begin
    rd_data_o = '0;
    for (int unsigned r = 0; r < NumRows; r++) begin
      if (rd_row_qq == RowW'(r)) begin
        rd_data_o = rd_dout[r*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/sram_db_banked.sv
// Double-buffered (ping-pong) SRAM built from two sram_bank_array buffers.
// The producer fills the write buffer while the consumer drains the read
// buffer; wr_done/rd_done swap roles. Read latency is two cycles.
// Optional SRAM_DB_ERR_EN: builds a sticky protocol-error flag on err_o;
// otherwise err_o is tied low.
module sram_db_banked
  import sram_db_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2048,
  parameter int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_done_i,
  output logic                  wr_ready_o,
  input  logic                  rd_en_i,
  input  logic [AW-1:0]         rd_addr_i,
  input  logic                  rd_done_i,
  output logic                  rd_ready_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  err_o
);

  full_cnt_t full_cnt_q, full_cnt_d;
  logic      wsel_q, wsel_d;
  logic      rsel_q, rsel_d;

  logic wr_acc, rd_acc, wr_done_acc, rd_done_acc;

  logic                  rd_v1_q, rd_v2_q;
  logic                  rd_buf1_q, rd_buf2_q;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic [1:0]            bank_wr_en;
  logic [1:0]            bank_rd_en;
  logic [DATA_WIDTH-1:0] bank_rd_data [2];

  assign wr_ready_o = (full_cnt_q != FullCntMax);
  assign rd_ready_o = (full_cnt_q != FullCntEmpty);

  assign wr_acc      = wr_en_i   & wr_ready_o;
  assign rd_acc      = rd_en_i   & rd_ready_o;
  assign wr_done_acc = wr_done_i & wr_ready_o;
  assign rd_done_acc = rd_done_i & rd_ready_o;

  // Ping-pong next state: each accepted done swaps its side's buffer.
  always_comb begin
    full_cnt_d = full_cnt_q;
    wsel_d     = wsel_q;
    rsel_d     = rsel_q;
    if (wr_done_acc) begin
      wsel_d = !wsel_q;
    end
    if (rd_done_acc) begin
      rsel_d = !rsel_q;
    end
    case ({wr_done_acc, rd_done_acc})
      2'b10:   full_cnt_d = full_cnt_q + 2'd1;
      2'b01:   full_cnt_d = full_cnt_q - 2'd1;
      default: full_cnt_d = full_cnt_q;
    endcase
  end

  // Ping-pong state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_cnt_q <= FullCntEmpty;
      wsel_q     <= 1'b0;
      rsel_q     <= 1'b0;
    end else begin
      full_cnt_q <= full_cnt_d;
      wsel_q     <= wsel_d;
      rsel_q     <= rsel_d;
    end
  end

  // Requests go to the buffer selected before any same-cycle swap.
  assign bank_wr_en = {wr_acc & wsel_q, wr_acc & !wsel_q};
  assign bank_rd_en = {rd_acc & rsel_q, rd_acc & !rsel_q};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    sram_bank_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (AW)
    ) u_bank (
      .clk_i     (clk_i),
      .wr_en_i   (bank_wr_en[b]),
      .wr_addr_i (wr_addr_i),
      .wr_data_i (wr_data_i),
      .rd_en_i   (bank_rd_en[b]),
      .rd_addr_i (rd_addr_i),
      .rd_data_o (bank_rd_data[b])
    );
  end

  // Read valid/buffer pipeline; reset drops every read in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_v1_q    <= 1'b0;
      rd_v2_q    <= 1'b0;
      rd_buf1_q  <= 1'b0;
      rd_buf2_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_v1_q    <= rd_acc;
      rd_v2_q    <= rd_v1_q;
      rd_buf2_q  <= rd_buf1_q;
      rd_valid_q <= rd_v2_q;
      if (rd_acc) begin
        rd_buf1_q <= rsel_q;
      end
      if (rd_v2_q) begin
        rd_data_q <= rd_buf2_q ? bank_rd_data[1] : bank_rd_data[0];
      end
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

`ifdef SRAM_DB_ERR_EN
  logic err_q;
  logic violation;

  assign violation = (wr_en_i   & !wr_ready_o) | (wr_done_i & !wr_ready_o) |
                     (rd_en_i   & !rd_ready_o) | (rd_done_i & !rd_ready_o);

  // Sticky until reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (violation) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sram_db_banked.sv
// Scoreboard bench for sram_db_banked (64-bit words, 1024-deep buffers).
module tb_sram_db_banked;

  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW    = 10;

`ifdef SRAM_DB_ERR_EN
  localparam logic ErrExp = 1'b1;
`else
  localparam logic ErrExp = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, wr_done, rd_en, rd_done;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready, rd_ready, rd_valid, err;
  logic [DW-1:0] rd_data;

  typedef struct packed {
    logic [63:0] data;
    int unsigned due;
  } exp_t;

  exp_t        sb_q [$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  sram_db_banked #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .wr_done_i  (wr_done),
    .wr_ready_o (wr_ready),
    .rd_en_i    (rd_en),
    .rd_addr_i  (rd_addr),
    .rd_done_i  (rd_done),
    .rd_ready_o (rd_ready),
    .rd_data_o  (rd_data),
    .rd_valid_o (rd_valid),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] pat(input int unsigned a);
    return {a, ~a};
  endfunction

  // Monitor: every returned read must match the oldest expectation, on time.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rd_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rd_valid", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("rd_data", rd_data, mon_e.data);
        check("rd_latency", 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int unsigned a, input logic [63:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // Expected data is due at the negedge three counts after issue.
  task automatic read(input int unsigned a, input logic [63:0] d, input bit accepted);
    rd_en   = 1'b1;
    rd_addr = AW'(a);
    if (accepted) sb_q.push_back('{data: d, due: cyc + 3});
    step();
    rd_en = 1'b0;
  endtask

  task automatic dones(input logic wd, input logic rdn);
    wr_done = wd;
    rd_done = rdn;
    step();
    wr_done = 1'b0;
    rd_done = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic chk_flags(input string name, input logic wr_r, input logic rd_r);
    @(negedge clk);
    check({name, "_wr_ready"}, 64'(wr_ready), 64'(wr_r));
    check({name, "_rd_ready"}, 64'(rd_ready), 64'(rd_r));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_done = 1'b0; rd_en = 1'b0; rd_done = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_wr_ready", 64'(wr_ready), 64'd1);
    check("reset_rd_ready", 64'(rd_ready), 64'd0);
    check("reset_rd_valid", 64'(rd_valid), 64'd0);
    check("reset_rd_data", rd_data, 64'd0);
    check("reset_err", 64'(err), 64'd0);
    step();

    // Fill B0 with {addr, ~addr}
    for (int unsigned a = 0; a < DEPTH; a++) write(a, pat(a));
    wr_done = 1'b1;
    @(negedge clk);
    check("rd_ready_before_done", 64'(rd_ready), 64'd0);
    step();
    wr_done = 1'b0;
    chk_flags("after_first_done", 1'b1, 1'b1);

    // Drain all of B0 back-to-back
    for (int unsigned a = 0; a < DEPTH; a++) read(a, pat(a), 1'b1);
    drain();

    // Fill B1, including both sides of the row boundary
    write(0,   64'hB1B1_0000_0000_0000);
    write(5,   64'hB1B1_0000_0000_0005);
    write(511, 64'hB1B1_0000_0000_01FF);
    write(512, 64'hB1B1_0000_0000_0200);
    dones(1'b1, 1'b0);
    chk_flags("both_full", 1'b0, 1'b1);

    // Writes and dones while full must be ignored
    write(5, 64'h0000_0000_0000_DEAD);
    @(negedge clk);
    check("err_after_wr_full", 64'(err), 64'(ErrExp));
    step();
    dones(1'b1, 1'b0);
    chk_flags("done_while_full", 1'b0, 1'b1);

    // Release B0; now reading B1
    dones(1'b0, 1'b1);
    chk_flags("after_rd_done", 1'b1, 1'b1);
    read(0,   64'hB1B1_0000_0000_0000, 1'b1);
    read(511, 64'hB1B1_0000_0000_01FF, 1'b1);
    read(512, 64'hB1B1_0000_0000_0200, 1'b1);
    read(5,   64'hB1B1_0000_0000_0005, 1'b1);
    drain();

    // Refill one word of B0, then swap both sides in one cycle
    write(7, 64'h7777_7777_7777_7777);
    dones(1'b1, 1'b1);
    chk_flags("simultaneous_done", 1'b1, 1'b1);
    read(5,   pat(5), 1'b1);
    read(7,   64'h7777_7777_7777_7777, 1'b1);
    read(6,   pat(6), 1'b1);
    read(511, pat(511), 1'b1);
    read(512, pat(512), 1'b1);
    drain();

    // Count was still one: a single rd_done empties it
    dones(1'b0, 1'b1);
    chk_flags("emptied", 1'b1, 1'b0);
    read(3, 64'd0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    @(negedge clk);
    check("err_sticky", 64'(err), 64'(ErrExp));
    step();

    // Reset one cycle after an accepted read
    dones(1'b1, 1'b0);
    read(0, 64'd0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_rd_valid_a", 64'(rd_valid), 64'd0);
    check("rst_rd_ready", 64'(rd_ready), 64'd0);
    check("rst_wr_ready", 64'(wr_ready), 64'd1);
    check("rst_err", 64'(err), 64'd0);
    step();
    @(negedge clk);
    check("rst_rd_valid_b", 64'(rd_valid), 64'd0);
    step();

    // Read while empty
    read(1, 64'd0, 1'b0);
    @(negedge clk);
    check("err_rd_empty", 64'(err), 64'(ErrExp));
    step();
    step();
    @(negedge clk);
    check("err_held", 64'(err), 64'(ErrExp));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("err_cleared", 64'(err), 64'd0);
    check("final_rd_valid", 64'(rd_valid), 64'd0);
    step();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_db_banked.md
# sram_db_banked

Parametrised double-buffered (ping-pong) SRAM for the ConvHLS accelerator, tiled from `sky130_sram_2kbyte_1rw1r_32x512_8` macros. A producer fills one buffer while a consumer drains the other, and the two swap roles through a done/ready handshake. The block sits between the HLS datapath and the input, weight and output staging, and generalises fixed-size tiled wrappers to any power-of-two depth and any multiple-of-32 width.

## Interface
Parameters:
- `DATA_WIDTH`, 32: word width; a multiple of 32, one macro column per 32 bits.
- `DEPTH`, 2048: words per buffer; a power of two, at least 512.
- `AW`, `$clog2(DEPTH)`: address width; derived, not overridden.

Ports:
- `clk` in 1: the single clock; drives every macro port (`clk0` and `clk1`).
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: write request into the current write buffer.
- `wr_addr` in AW: write word address.
- `wr_data` in DATA_WIDTH: write data; full-word write, `wmask0` tied all-ones.
- `wr_done` in 1: the producer has finished the current write buffer.
- `wr_ready` out 1: a write buffer is available.
- `rd_en` in 1: read request from the current read buffer.
- `rd_addr` in AW: read word address.
- `rd_done` in 1: the consumer has finished the current read buffer.
- `rd_ready` out 1: a full buffer is available for reading.
- `rd_data` out DATA_WIDTH: registered read data.
- `rd_valid` out 1: `rd_data` holds the result of an accepted read.
- `err` out 1: sticky protocol-error flag (see Configuration).

## Operation
- Two buffers, B0 and B1, each `DEPTH/512` rows × `DATA_WIDTH/32` columns of macros. Port 0 is used for writes only; port 1 for reads only.
- State registers: `wsel` (write buffer), `rsel` (read buffer), `full_cnt` (0..2).
- `wr_ready = (full_cnt != 2)`; `rd_ready = (full_cnt != 0)`.
- A write is accepted when `wr_en & wr_ready`. A read is accepted when `rd_en & rd_ready`. Requests that are not accepted have no effect on memory or outputs.
- Accepted `wr_done` (requires `wr_ready`): `full_cnt` += 1 and `wsel` toggles. Accepted `rd_done` (requires `rd_ready`): `full_cnt` −= 1 and `rsel` toggles. If both are accepted in the same cycle, `full_cnt` is unchanged and both selects toggle.
- A write or read in the same cycle as its own `done` targets the old buffer; the swap takes effect the next cycle.
- Chip select for the macro at row r of buffer b on port 0: `csb0 = !(wr_acc & wsel==b & wr_addr[AW-1:9]==r)`. Port 1 uses the same form with `rd_acc`, `rsel` and `rd_addr`. At most one row per buffer is active per port per cycle.
- Read mux: buffer and row select are registered at accept. The macro output is muxed in cycle t+1 and captured into `rd_data` at the end of t+1.
- `rd_data` holds its last value when no read returns.
- Reset values: `full_cnt=0`, `wsel=0`, `rsel=0`, `rd_valid=0`, `rd_data=0`, `err=0`, hence `wr_ready=1` and `rd_ready=0`. Memory contents are not cleared.
- Reset mid-operation discards all in-flight reads: `rd_valid` is low the cycle after reset even if a read was accepted in the reset cycle.

## Timing
- Write: accepted at edge t; the macro registers it at t and the data is stored at the negedge of t. The word can be read at t+1 once the buffer has been swapped.
- Read latency is 2 cycles: a read accepted at edge t gives `rd_data`/`rd_valid` valid after edge t+2. Fully pipelined, one read per cycle.
- `wr_ready` and `rd_ready` update the cycle after a `done` is accepted.
- A buffer released by `rd_done` at t may be written from t+1. This is safe because the port-1 read of t completes at the negedge of t.

## Configuration
- `SRAM_DB_ERR_EN` defined: `err` is set, and stays set until `rst`, on any of `wr_en & !wr_ready`, `wr_done & !wr_ready`, `rd_en & !rd_ready`, `rd_done & !rd_ready`.
- Not defined: `err` is tied to 0 and no detection logic is built.

## Structure
- Package `sram_db_pkg`: `MACRO_DEPTH=512`, `MACRO_WIDTH=32`, `MACRO_AW=9`, and the `full_cnt` type (2-bit).
- Sub-module `sram_bank_array`: one buffer. It tiles the macros, decodes row chip selects, registers the read row and muxes the read output. It is instantiated twice. The top level holds the ping-pong control, the `rd_data` register, valid pipeline and `err`.

## Test plan
- Reset, then `DATA_WIDTH=64`, `DEPTH=1024`: write addresses 0..1023 with value `{addr, ~addr}`, `wr_done`, then read all words. Expected: `rd_ready` rises one cycle after `wr_done`; each read returns its value exactly 2 cycles later, back-to-back.
- Fill B0 and B1 (two `wr_done`s). Expected: `wr_ready=0`. A further `wr_en` to address 5 with 0xDEAD is ignored; after `rd_done`, B0 address 5 still holds its original value.
- With one full buffer, assert `wr_done` and `rd_done` in the same cycle. Expected: `full_cnt` stays 1, both selects toggle, and the next read comes from the newly filled buffer.
- Row boundary: write addresses 511 and 512 with different values and read them back on consecutive cycles. Expected: correct data on back-to-back cycles across the macro row change.
- Assert `rst` one cycle after a read is accepted. Expected: `rd_valid` stays 0, `rd_ready=0`, `wr_ready=1`.
- With `SRAM_DB_ERR_EN` defined, `rd_en` while empty. Expected: `err=1` next cycle, cleared only by `rst`. With the macro undefined, `err` stays 0.
